// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared constants for the pipeline hazard/forwarding controller.
// Bypass select encodings and the hazard FSM state type.
package hazard_fwd_ctrl_pkg;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_LU_STALL = 2'd1,
        HZ_MEM_WAIT = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_select.sv
// Bypass select for one EX operand: the younger EX/MEM result beats MEM/WB,
// and writes to register 0 never forward.
module hazard_fwd_ctrl_fwd_select
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] src_i,
    input  logic [RA_W-1:0] exmem_rd_i,
    input  logic [RA_W-1:0] memwb_rd_i,
    input  logic            exmem_regwrite_i,
    input  logic            memwb_regwrite_i,
    output logic [1:0]      sel_o
);

    logic exmem_hit;
    logic memwb_hit;

    assign exmem_hit = exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == src_i);
    assign memwb_hit = memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == src_i);

    always_comb begin
        sel_o = FWD_NONE;
        if (exmem_hit) begin
            sel_o = FWD_EXMEM;
        end else if (memwb_hit) begin
            sel_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Pipeline hazard control: EX bypass selects, load-use stalls, dmem-wait freeze,
// redirect squash. Define HAZARD_PERF_EN to add saturating perf counters.
//
// state       | meaning
// HZ_RUN      | normal flow; a load-use hit stalls here and may enter HZ_LU_STALL
// HZ_LU_STALL | extra load-use stall cycles, cnt_q = cycles left including this one
// HZ_MEM_WAIT | dmem wait freeze; saved_q remembers which state to resume
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int RA_W     = 5,
    parameter int LOAD_LAT = 1,
    parameter int PERF_W   = 16
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic [RA_W-1:0] ifid_rs_i,
    input  logic [RA_W-1:0] ifid_rt_i,
    input  logic            ifid_uses_rs_i,
    input  logic            ifid_uses_rt_i,
    input  logic [RA_W-1:0] idex_rs_i,
    input  logic [RA_W-1:0] idex_rt_i,
    input  logic            idex_memread_i,
    input  logic [RA_W-1:0] exmem_rd_i,
    input  logic [RA_W-1:0] memwb_rd_i,
    input  logic            exmem_regwrite_i,
    input  logic            memwb_regwrite_i,
    input  logic            dmem_req_i,
    input  logic            dmem_ready_i,
    input  logic            redirect_i,
    output logic [1:0]      bypass_a_o,
    output logic [1:0]      bypass_b_o,
    output logic            pc_write_o,
    output logic            ifid_write_o,
    output logic            idex_bubble_o,
    output logic            ifid_flush_o,
    output logic            freeze_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_o,
    output logic [PERF_W-1:0] perf_freeze_o,
    output logic [PERF_W-1:0] perf_flush_o
`endif
);

    localparam int CNT_W = $clog2(LOAD_LAT + 1);

    if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_bad_load_lat
        $error("hazard_fwd_ctrl: LOAD_LAT must be in 1..7");
    end
    if (PERF_W < 1) begin : g_bad_perf_w
        $error("hazard_fwd_ctrl: PERF_W must be at least 1");
    end

    logic [1:0] sel_a;
    logic [1:0] sel_b;

    hazard_fwd_ctrl_fwd_select #(.RA_W(RA_W)) u_fwd_a (
        .src_i            (idex_rs_i),
        .exmem_rd_i       (exmem_rd_i),
        .memwb_rd_i       (memwb_rd_i),
        .exmem_regwrite_i (exmem_regwrite_i),
        .memwb_regwrite_i (memwb_regwrite_i),
        .sel_o            (sel_a)
    );

    hazard_fwd_ctrl_fwd_select #(.RA_W(RA_W)) u_fwd_b (
        .src_i            (idex_rt_i),
        .exmem_rd_i       (exmem_rd_i),
        .memwb_rd_i       (memwb_rd_i),
        .exmem_regwrite_i (exmem_regwrite_i),
        .memwb_regwrite_i (memwb_regwrite_i),
        .sel_o            (sel_b)
    );

    assign bypass_a_o = reset_i ? sel_a : FWD_NONE;
    assign bypass_b_o = reset_i ? sel_b : FWD_NONE;

    hz_state_e        state_q, state_d;
    hz_state_e        saved_q, saved_d;
    hz_state_e        run_state;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frz;
    logic             lu_hit;

    assign frz    = dmem_req_i && !dmem_ready_i;
    assign lu_hit = idex_memread_i && (idex_rt_i != '0) &&
                    ((ifid_uses_rs_i && (idex_rt_i == ifid_rs_i)) ||
                     (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

    // Once the freeze lifts, that same cycle behaves as the interrupted state.
    assign run_state = (state_q == HZ_MEM_WAIT) ? saved_q : state_q;

    always_comb begin
        state_d       = state_q;
        saved_d       = saved_q;
        cnt_d         = cnt_q;
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        idex_bubble_o = 1'b0;
        ifid_flush_o  = 1'b0;
        freeze_o      = 1'b0;

        if (frz) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            freeze_o     = 1'b1;
            saved_d      = run_state;
            state_d      = HZ_MEM_WAIT;
        end else if (redirect_i) begin
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
            cnt_d         = '0;
            state_d       = HZ_RUN;
        end else if (run_state == HZ_LU_STALL) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            cnt_d         = cnt_q - CNT_W'(1);
            state_d       = (cnt_q == CNT_W'(1)) ? HZ_RUN : HZ_LU_STALL;
        end else if (lu_hit) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            state_d       = HZ_RUN;
            if (LOAD_LAT > 1) begin
                cnt_d   = CNT_W'(LOAD_LAT - 1);
                state_d = HZ_LU_STALL;
            end
        end else begin
            state_d = HZ_RUN;
        end

        if (!reset_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            ifid_flush_o  = 1'b1;
            freeze_o      = 1'b0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= HZ_RUN;
            saved_q <= HZ_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic lu_cyc;
    logic redir_cyc;
    logic [PERF_W-1:0] perf_stall_q, perf_freeze_q, perf_flush_q;

    assign lu_cyc    = !frz && !redirect_i && ((run_state == HZ_LU_STALL) || lu_hit);
    assign redir_cyc = !frz && redirect_i;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            perf_stall_q  <= '0;
            perf_freeze_q <= '0;
            perf_flush_q  <= '0;
        end else begin
            if (lu_cyc && !(&perf_stall_q))     perf_stall_q  <= perf_stall_q + 1'b1;
            if (frz && !(&perf_freeze_q))       perf_freeze_q <= perf_freeze_q + 1'b1;
            if (redir_cyc && !(&perf_flush_q))  perf_flush_q  <= perf_flush_q + 1'b1;
        end
    end

    assign perf_stall_o  = perf_stall_q;
    assign perf_freeze_o = perf_freeze_q;
    assign perf_flush_o  = perf_flush_q;
`endif

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Parametrised successor to the ID-stage stall detector and EX-stage bypass detector; one block owns all pipeline hazard control.
- Generates EX operand bypass selects and pc/IF-ID write enables, plus ID/EX bubble and IF/ID flush.
- Adds multi-cycle load-use stalls, data-memory wait freeze, and branch/jump squash.
- Sits beside the 5-stage datapath; consumes pipeline-register fields and drives their enables.

Parameters:
RA_W, 5, register-address width.
LOAD_LAT, 1, load-use stall cycles (1..7).
PERF_W, 16, perf counter width (used only with HAZARD_PERF_EN).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
ifid_rs, ifid_rt  in  RA_W  source regs of instruction in ID.
ifid_uses_rs, ifid_uses_rt  in  1  ID instruction actually reads rs/rt.
idex_rs, idex_rt  in  RA_W  source regs in EX.
idex_memread  in  1  EX instruction is a load.
exmem_rd, memwb_rd  in  RA_W  destination regs.
exmem_regwrite, memwb_regwrite  in  1  write enables.
dmem_req  in  1  MEM stage accessing data memory.
dmem_ready  in  1  data memory completes this cycle.
redirect  in  1  taken branch or jump resolved in EX.
bypassA, bypassB  out  2  00 regfile, 01 MEM/WB, 10 EX/MEM.
pc_write, ifid_write  out  1  hold PC / IF-ID when 0.
idex_bubble  out  1  zero ID/EX control bits.
ifid_flush  out  1  zero IF/ID instruction.
freeze  out  1  hold ID/EX, EX/MEM, MEM/WB.

Behaviour:
- Reset (reset=0, async):
  - state=RUN, stall counter=0.
  - While reset is low: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=1, freeze=0, bypass=00.
- Bypass (combinational, every cycle):
  - A: EX/MEM match wins (regwrite & rd!=0 & rd==idex_rs) -> 10.
  - Otherwise MEM/WB match -> 01.
  - Otherwise 00.
  - B identical on idex_rt.
  - Bypass outputs are unaffected by freeze/stall.
- Hazard detect (lu_hit): idex_memread & ((ifid_uses_rs & idex_rt==ifid_rs) | (ifid_uses_rt & idex_rt==ifid_rt)). Matches on reg 0 are ignored.
- States: RUN, LU_STALL, MEM_WAIT. Priority per cycle: freeze > redirect > load-use.
- MEM_WAIT condition (any state): dmem_req & !dmem_ready.
  - Outputs: freeze=1, pc_write=0, ifid_write=0, others 0.
  - Next state MEM_WAIT.
  - The stall counter is held, not decremented.
  - On dmem_ready=1, return to the saved state (RUN or LU_STALL).
- Redirect (not frozen):
  - ifid_flush=1, idex_bubble=1, pc_write=1.
  - Abort any LU_STALL: counter=0, state=RUN.
- RUN & lu_hit (no redirect/freeze):
  - pc_write=0, ifid_write=0, idex_bubble=1.
  - If LOAD_LAT>1: counter<=LOAD_LAT-1, state<=LU_STALL.
  - Else remain in RUN. This is the single-cycle legacy behaviour.
- LU_STALL:
  - Same stall outputs; counter decrements each cycle.
  - When counter==1, next state RUN.
  - Normal flow resumes the cycle after the counter hits 0.
- RUN without hazards: pc_write=1, ifid_write=1, all else 0.
- Counter width: clog2(LOAD_LAT+1). LOAD_LAT=0 is illegal; an elaboration-time error is required.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Enabled adds outputs perf_stall, perf_freeze, perf_flush (PERF_W each). They count load-use stall cycles, freeze cycles, and redirect cycles.
- Counters saturate at all-ones; reset clears them to 0.
- Disabled: ports and counters absent; behaviour otherwise identical.

Decomposition:
- constants.h gets `FWD_NONE 2'b00, `FWD_MEMWB 2'b01, `FWD_EXMEM 2'b10, and the state encodings `HZ_RUN/`HZ_LU_STALL/`HZ_MEM_WAIT.
- One sub-module, fwd_select (one operand's compare/priority), instantiated twice (A, B).

Test Plan:
- exmem rd=3 regwrite=1, memwb rd=3 regwrite=1, idex_rs=3 -> bypassA=10; drop exmem_regwrite -> bypassA=01; rd=0 -> 00.
- LOAD_LAT=1: idex_memread=1, idex_rt=5, ifid_rs=5, uses_rs=1 -> one cycle pc_write=0, idex_bubble=1; with uses_rs=0 -> no stall.
- LOAD_LAT=3, same hit -> exactly 3 consecutive stall cycles, then pc_write=1.
- During a LOAD_LAT=3 stall (2nd cycle), dmem_req=1, dmem_ready=0 for 4 cycles -> freeze=1 for 4 cycles; counter held; 2 stall cycles follow.
- redirect=1 coincident with lu_hit -> ifid_flush=1, idex_bubble=1, pc_write=1, state RUN. Redirect with freeze -> no flush until dmem_ready.
- Assert reset mid-LU_STALL -> outputs take reset values immediately; after release state RUN; with HAZARD_PERF_EN, counters=0 and perf_stall saturates at 0xFFFF.
